// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Register file with two read ports and two write ports, for the multi-issue
// datapath. Port A carries ALU writeback and port B carries memory/load
// writeback. A per-register pending-write scoreboard flags load-use hazards.
// A sequencer sweeps every entry back to zero between kernel runs.
//
// Ports:
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   rd_addr_1_i/2_i       read port addresses
//   rd_data_1_o/2_o       read port data (combinational, zero latency)
//   wr_en_a_i, wr_addr_a_i, wr_data_a_i   write port A (ALU)
//   wr_en_b_i, wr_addr_b_i, wr_data_b_i   write port B (load); also clears busy
//   busy_set_i, busy_set_addr_i           mark a register as pending load dest
//   busy_1_o/2_o          pending-write flags for the two read addresses
//   clr_start_i           single-cycle pulse that starts a clear sweep
//   clr_busy_o            high while the clear sweep runs
// -----------------------------------------------------------------------------
module regfile_mp #(
   parameter int DATA_W   = 24,
   parameter int ADDR_W   = 4,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] rd_addr_1_i,
   input  logic [ADDR_W-1:0] rd_addr_2_i,
   output logic [DATA_W-1:0] rd_data_1_o,
   output logic [DATA_W-1:0] rd_data_2_o,
   input  logic              wr_en_a_i,
   input  logic [ADDR_W-1:0] wr_addr_a_i,
   input  logic [DATA_W-1:0] wr_data_a_i,
   input  logic              wr_en_b_i,
   input  logic [ADDR_W-1:0] wr_addr_b_i,
   input  logic [DATA_W-1:0] wr_data_b_i,
   input  logic              busy_set_i,
   input  logic [ADDR_W-1:0] busy_set_addr_i,
   output logic              busy_1_o,
   output logic              busy_2_o,
   input  logic              clr_start_i,
   output logic              clr_busy_o
);

   localparam int NUM_REGS = 2**ADDR_W;

   typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   cnt_q;
   logic                clr_busy_q;
   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;

   logic in_idle;
   logic we_a;
   logic we_b;
   logic bset;
   logic fwd_en;

   assign in_idle = (state_q == ST_IDLE);

   // External writes and scoreboard sets are locked out during the sweep;
   // with the zero register enabled, anything aimed at address 0 is dropped.
   assign we_a = wr_en_a_i  && in_idle && !((ZERO_REG != 0) && (wr_addr_a_i == '0));
   assign we_b = wr_en_b_i  && in_idle && !((ZERO_REG != 0) && (wr_addr_b_i == '0));
   assign bset = busy_set_i && in_idle && !((ZERO_REG != 0) && (busy_set_addr_i == '0));

   // Forwarding is off during the sweep so reads show the array as swept so far.
   assign fwd_en = (BYPASS != 0) && in_idle;

   // Clear sequencer: IDLE -> CLEAR for exactly NUM_REGS cycles, cnt walks
   // every address once and wraps back to 0 on the final increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         clr_busy_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (clr_start_i) begin
                  state_q    <= ST_CLEAR;
                  cnt_q      <= '0;
                  clr_busy_q <= 1'b1;
               end
            end
            ST_CLEAR: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == ADDR_W'(NUM_REGS - 1)) begin
                  state_q    <= ST_IDLE;
                  clr_busy_q <= 1'b0;
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               clr_busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign clr_busy_o = clr_busy_q;

   // Register array. Port B is applied after port A so it wins on a collision.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (!in_idle) begin
         regs_q[cnt_q] <= '0;
      end else begin
         if (we_a) regs_q[wr_addr_a_i] <= wr_data_a_i;
         if (we_b) regs_q[wr_addr_b_i] <= wr_data_b_i;
      end
   end

   // Scoreboard next state: a load completing on port B retires the pending
   // flag, but a new busy_set to the same register in the same cycle is a new
   // producer and must win, so the set is applied last.
   always_comb begin
      busy_d = busy_q;
      if (!in_idle) begin
         busy_d[cnt_q] = 1'b0;
      end else begin
         if (we_b) busy_d[wr_addr_b_i]     = 1'b0;
         if (bset) busy_d[busy_set_addr_i] = 1'b1;
      end
      if (ZERO_REG != 0) busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy_q <= '0;
      else        busy_q <= busy_d;
   end

   // Read ports share one mux structure; port B forwarding has priority over
   // port A, matching the write-collision rule.
   for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              busy;
      logic              hit_a;
      logic              hit_b;

      assign addr  = (gi == 0) ? rd_addr_1_i : rd_addr_2_i;
      assign hit_a = fwd_en && wr_en_a_i && (wr_addr_a_i == addr);
      assign hit_b = fwd_en && wr_en_b_i && (wr_addr_b_i == addr);

      always_comb begin
         data = regs_q[addr];
         if (hit_b)      data = wr_data_b_i;
         else if (hit_a) data = wr_data_a_i;
         if ((ZERO_REG != 0) && (addr == '0)) data = '0;
      end

      // A load landing this cycle resolves the hazard immediately when forwarded.
      assign busy = busy_q[addr] && !hit_b;
   end

   assign rd_data_1_o = g_rd[0].data;
   assign rd_data_2_o = g_rd[1].data;
   assign busy_1_o    = g_rd[0].busy;
   assign busy_2_o    = g_rd[1].busy;

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
// Self-checking bench for regfile_mp. Two instances share all inputs: one with
// forwarding (default parameters) and one with BYPASS=0. Expected values are
// queued when stimulus is applied and compared at the following falling edge.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

   localparam int DW = 24;
   localparam int AW = 4;

   localparam int S_RD1  = 0;
   localparam int S_RD2  = 1;
   localparam int S_B1   = 2;
   localparam int S_B2   = 3;
   localparam int S_CB   = 4;
   localparam int S_NRD1 = 5;
   localparam int S_NB1  = 6;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] rd_addr_1, rd_addr_2;
   logic [DW-1:0] rd_data_1, rd_data_2;
   logic          wr_en_a, wr_en_b, busy_set, clr_start;
   logic [AW-1:0] wr_addr_a, wr_addr_b, busy_set_addr;
   logic [DW-1:0] wr_data_a, wr_data_b;
   logic          busy_1, busy_2, clr_busy;
   logic [DW-1:0] nb_rd_data_1, nb_rd_data_2;
   logic          nb_busy_1, nb_busy_2, nb_clr_busy;

   typedef struct {
      int          sel;
      logic [31:0] exp;
      string       tag;
   } exp_t;

   exp_t          sb_q[$];
   int            n_checks = 0;
   int            n_fail   = 0;
   int            n_txn    = 0;
   logic [DW-1:0] mdl [16];

   always #5 clk = ~clk;

   regfile_mp dut (
      .clk(clk), .rst_n(rst_n),
      .rd_addr_1_i(rd_addr_1), .rd_addr_2_i(rd_addr_2),
      .rd_data_1_o(rd_data_1), .rd_data_2_o(rd_data_2),
      .wr_en_a_i(wr_en_a), .wr_addr_a_i(wr_addr_a), .wr_data_a_i(wr_data_a),
      .wr_en_b_i(wr_en_b), .wr_addr_b_i(wr_addr_b), .wr_data_b_i(wr_data_b),
      .busy_set_i(busy_set), .busy_set_addr_i(busy_set_addr),
      .busy_1_o(busy_1), .busy_2_o(busy_2),
      .clr_start_i(clr_start), .clr_busy_o(clr_busy)
   );

   regfile_mp #(.BYPASS(0)) dut_nb (
      .clk(clk), .rst_n(rst_n),
      .rd_addr_1_i(rd_addr_1), .rd_addr_2_i(rd_addr_2),
      .rd_data_1_o(nb_rd_data_1), .rd_data_2_o(nb_rd_data_2),
      .wr_en_a_i(wr_en_a), .wr_addr_a_i(wr_addr_a), .wr_data_a_i(wr_data_a),
      .wr_en_b_i(wr_en_b), .wr_addr_b_i(wr_addr_b), .wr_data_b_i(wr_data_b),
      .busy_set_i(busy_set), .busy_set_addr_i(busy_set_addr),
      .busy_1_o(nb_busy_1), .busy_2_o(nb_busy_2),
      .clr_start_i(clr_start), .clr_busy_o(nb_clr_busy)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] observe(input int sel);
      case (sel)
         S_RD1:   return {8'h00, rd_data_1};
         S_RD2:   return {8'h00, rd_data_2};
         S_B1:    return {31'h0, busy_1};
         S_B2:    return {31'h0, busy_2};
         S_CB:    return {31'h0, clr_busy};
         S_NRD1:  return {8'h00, nb_rd_data_1};
         S_NB1:   return {31'h0, nb_busy_1};
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

   task automatic expect_v(input int sel, input logic [31:0] e, input string tag);
      exp_t item;
      item.sel = sel;
      item.exp = e;
      item.tag = tag;
      sb_q.push_back(item);
   endtask

   task automatic sb_drain();
      int   n;
      exp_t item;
      n = sb_q.size();
      while (sb_q.size() > 0) begin
         item = sb_q.pop_front();
         check_val(item.tag, observe(item.sel), item.exp);
      end
      $display("txn %0d: rd1=%0h rd2=%0h %0d checks", n_txn, rd_addr_1, rd_addr_2, n);
      n_txn++;
   endtask

   // Outputs sampled at the falling edge; inputs change 1 unit after the rise.
   task automatic step();
      @(negedge clk);
      sb_drain();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en_a = 1'b0; wr_addr_a = '0; wr_data_a = '0;
      wr_en_b = 1'b0; wr_addr_b = '0; wr_data_b = '0;
      busy_set = 1'b0; busy_set_addr = '0; clr_start = 1'b0;
   endtask

   task automatic fill_regs();
      logic [31:0] v;
      for (int i = 1; i < 16; i++) begin
         idle();
         v = 32'h00A0_0000 ^ (i * 32'h0001_2345);
         mdl[i] = v[DW-1:0];
         if (i % 2 == 1) begin
            wr_en_a = 1'b1; wr_addr_a = AW'(i); wr_data_a = v[DW-1:0];
         end else begin
            wr_en_b = 1'b1; wr_addr_b = AW'(i); wr_data_b = v[DW-1:0];
         end
         if (i == 9 || i == 12) begin
            busy_set = 1'b1; busy_set_addr = AW'(i);
         end
         step();
      end
      idle();
   endtask

   task automatic read_all_zero(input string tag);
      for (int i = 0; i < 16; i++) begin
         rd_addr_1 = AW'(i);
         rd_addr_2 = AW'(15 - i);
         expect_v(S_RD1, 32'h0, {tag, "_rd1"});
         expect_v(S_RD2, 32'h0, {tag, "_rd2"});
         expect_v(S_B1,  32'h0, {tag, "_busy1"});
         expect_v(S_B2,  32'h0, {tag, "_busy2"});
         step();
      end
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      rd_addr_1 = '0;
      rd_addr_2 = '0;
      for (int i = 0; i < 16; i++) mdl[i] = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      rd_addr_1 = 4'd6;
      expect_v(S_CB,  32'h0, "rst_clr_busy");
      expect_v(S_RD1, 32'h0, "rst_rd1");
      step();
      rst_n = 1'b1;
      expect_v(S_CB, 32'h0, "post_rst_clr_busy");
      read_all_zero("reset");

      // Same-cycle write/read on port A
      wr_en_a = 1'b1; wr_addr_a = 4'd3; wr_data_a = 24'h0ABCDE;
      rd_addr_1 = 4'd3;
      expect_v(S_RD1,  32'h0ABCDE, "bypass_a_rd1");
      expect_v(S_NRD1, 32'h0,      "nobypass_a_rd1");
      step();
      idle();
      expect_v(S_RD1,  32'h0ABCDE, "after_a_rd1");
      expect_v(S_NRD1, 32'h0ABCDE, "nobypass_after_a_rd1");
      step();

      // A/B collision: B wins, both in forwarding and in the array
      wr_en_a = 1'b1; wr_addr_a = 4'd5; wr_data_a = 24'h111111;
      wr_en_b = 1'b1; wr_addr_b = 4'd5; wr_data_b = 24'h222222;
      rd_addr_1 = 4'd5;
      expect_v(S_RD1, 32'h222222, "collide_fwd_rd1");
      step();
      idle();
      expect_v(S_RD1,  32'h222222, "collide_rd1");
      expect_v(S_NRD1, 32'h222222, "nobypass_collide_rd1");
      step();

      // Zero register
      wr_en_a = 1'b1; wr_addr_a = 4'd0; wr_data_a = 24'hFFFFFF;
      rd_addr_1 = 4'd0;
      expect_v(S_RD1, 32'h0, "zero_fwd_rd1");
      step();
      idle();
      expect_v(S_RD1,  32'h0, "zero_rd1");
      expect_v(S_NRD1, 32'h0, "nobypass_zero_rd1");
      step();

      // Scoreboard
      busy_set = 1'b1; busy_set_addr = 4'd7;
      rd_addr_1 = 4'd7; rd_addr_2 = 4'd7;
      expect_v(S_B1, 32'h0, "bset_same_cycle_busy1");
      step();
      idle();
      expect_v(S_B1,  32'h1, "bset_busy1");
      expect_v(S_B2,  32'h1, "bset_busy2");
      expect_v(S_NB1, 32'h1, "nobypass_bset_busy1");
      step();
      wr_en_b = 1'b1; wr_addr_b = 4'd7; wr_data_b = 24'h00BEEF;
      expect_v(S_B1,   32'h0,      "load_fwd_busy1");
      expect_v(S_RD1,  32'h00BEEF, "load_fwd_rd1");
      expect_v(S_NB1,  32'h1,      "nobypass_load_busy1");
      expect_v(S_NRD1, 32'h0,      "nobypass_load_rd1");
      step();
      idle();
      expect_v(S_B1,   32'h0,      "load_done_busy1");
      expect_v(S_NB1,  32'h0,      "nobypass_load_done_busy1");
      expect_v(S_NRD1, 32'h00BEEF, "nobypass_load_done_rd1");
      step();
      busy_set = 1'b1; busy_set_addr = 4'd7;
      wr_en_b = 1'b1; wr_addr_b = 4'd7; wr_data_b = 24'h000123;
      expect_v(S_RD1, 32'h000123, "set_clr_fwd_rd1");
      step();
      idle();
      expect_v(S_B1,  32'h1,      "set_wins_busy1");
      expect_v(S_NB1, 32'h1,      "nobypass_set_wins_busy1");
      expect_v(S_RD1, 32'h000123, "set_clr_rd1");
      step();
      wr_en_a = 1'b1; wr_addr_a = 4'd7; wr_data_a = 24'h000456;
      expect_v(S_RD1, 32'h000456, "a_fwd_rd1");
      expect_v(S_B1,  32'h1,      "a_fwd_busy1");
      step();
      idle();
      expect_v(S_B1,  32'h1,      "a_keeps_busy1");
      expect_v(S_RD1, 32'h000456, "a_write_rd1");
      step();
      busy_set = 1'b1; busy_set_addr = 4'd0;
      step();
      idle();
      rd_addr_1 = 4'd0;
      expect_v(S_B1, 32'h0, "zero_busy1");
      step();

      // Clear sweep
      fill_regs();
      rd_addr_1 = 4'd9; rd_addr_2 = 4'd12;
      expect_v(S_B1,  32'h1, "fill_busy9");
      expect_v(S_B2,  32'h1, "fill_busy12");
      expect_v(S_RD1, {8'h00, mdl[9]}, "fill_rd9");
      clr_start = 1'b1;
      expect_v(S_CB, 32'h0, "start_clr_busy");
      step();
      for (int k = 0; k < 16; k++) begin
         idle();
         rd_addr_1 = 4'd3; rd_addr_2 = 4'd0;
         expect_v(S_CB, 32'h1, $sformatf("sweep%0d_clr_busy", k));
         if (k == 0) begin
            rd_addr_1 = 4'd15; rd_addr_2 = 4'd9;
            expect_v(S_RD1, {8'h00, mdl[15]}, "sweep_unswept_rd1");
            expect_v(S_B2,  32'h1,            "sweep_unswept_busy2");
         end
         if (k == 5) begin
            wr_en_a = 1'b1; wr_addr_a = 4'd2;  wr_data_a = 24'h0F0F0F;
            wr_en_b = 1'b1; wr_addr_b = 4'd14; wr_data_b = 24'h333333;
            busy_set = 1'b1; busy_set_addr = 4'd3;
            clr_start = 1'b1;
            rd_addr_1 = 4'd14; rd_addr_2 = 4'd1;
            expect_v(S_RD1, {8'h00, mdl[14]}, "sweep_no_fwd_rd1");
            expect_v(S_RD2, 32'h0,            "sweep_swept_rd2");
         end
         step();
      end
      idle();
      expect_v(S_CB, 32'h0, "sweep_end_clr_busy");
      step();
      read_all_zero("swept");

      // Reset in the middle of a sweep
      fill_regs();
      clr_start = 1'b1;
      step();
      idle();
      for (int k = 0; k < 6; k++) begin
         expect_v(S_CB, 32'h1, $sformatf("abort%0d_clr_busy", k));
         step();
      end
      rst_n = 1'b0;
      rd_addr_1 = 4'd10; rd_addr_2 = 4'd15;
      #1;
      expect_v(S_CB,  32'h0, "abort_clr_busy");
      expect_v(S_RD1, 32'h0, "abort_rd10");
      expect_v(S_RD2, 32'h0, "abort_rd15");
      sb_drain();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      read_all_zero("abort");
      clr_start = 1'b1;
      expect_v(S_CB, 32'h0, "restart_clr_busy");
      step();
      idle();
      for (int k = 0; k < 16; k++) begin
         expect_v(S_CB, 32'h1, $sformatf("restart%0d_clr_busy", k));
         step();
      end
      expect_v(S_CB, 32'h0, "restart_end_clr_busy");
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the single-write-port 24-bit, 16-entry register file in the project 2 microarchitecture.
- Two read ports and two write ports: port A for ALU writeback, port B for memory/load writeback.
- Optional write-to-read bypass and hardwired zero register.
- A per-register pending-write scoreboard for load-use hazard detection, plus a multi-cycle clear sequencer used between kernel runs.

Parameters:
DATA_W, 24, register width in bits
ADDR_W, 4, register address width; NUM_REGS = 2**ADDR_W (derived, not overridable)
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads see array only
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and busy_set; 0 = register 0 is ordinary

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
rd_addr_1  input  ADDR_W  read port 1 address
rd_addr_2  input  ADDR_W  read port 2 address
rd_data_1  output  DATA_W  read port 1 data (combinational)
rd_data_2  output  DATA_W  read port 2 data (combinational)
wr_en_a  input  1  write port A enable
wr_addr_a  input  ADDR_W  write port A address
wr_data_a  input  DATA_W  write port A data
wr_en_b  input  1  write port B enable; also clears scoreboard bit
wr_addr_b  input  ADDR_W  write port B address
wr_data_b  input  DATA_W  write port B data
busy_set  input  1  mark busy_set_addr as pending load destination
busy_set_addr  input  ADDR_W  scoreboard set address
busy_1  output  1  pending-write flag for rd_addr_1
busy_2  output  1  pending-write flag for rd_addr_2
clr_start  input  1  start clear sweep (single-cycle pulse)
clr_busy  output  1  clear sweep in progress

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers = 0; all busy bits = 0.
  - FSM = IDLE; clr_busy = 0.
  - Outputs: rd_data_x = 0 and busy_x = 0.
- Writes (rising edge):
  - Port A writes reg[wr_addr_a] when wr_en_a.
  - Port B writes reg[wr_addr_b] when wr_en_b.
  - Both enabled to the same address: port B wins.
  - ZERO_REG=1: writes to address 0 dropped.
- Reads (combinational, zero latency):
  - ZERO_REG=1 and addr 0: return 0.
  - Otherwise, if BYPASS=1: port B hit (wr_en_b and wr_addr_b==rd_addr) returns wr_data_b; else port A hit returns wr_data_a; else the array value.
  - BYPASS=0: array value only; the new value is visible in the cycle after the write edge.
- Scoreboard:
  - busy_set sets busy[busy_set_addr] at the edge.
  - wr_en_b clears busy[wr_addr_b] at the edge.
  - Set and clear on the same address in the same cycle: set wins (new producer).
  - Port A writes never affect busy.
  - ZERO_REG=1: busy[0] is always 0.
  - busy_x = busy[rd_addr_x] AND NOT (BYPASS and wr_en_b and wr_addr_b==rd_addr_x).
- Clear FSM, states IDLE and CLEAR, with an ADDR_W-bit counter cnt:
  - IDLE + clr_start → CLEAR with cnt=0 at the next edge.
  - In CLEAR, each edge writes reg[cnt]=0 and busy[cnt]=0, then cnt increments.
  - At cnt==NUM_REGS-1 the final entry is cleared and the FSM returns to IDLE. CLEAR lasts exactly NUM_REGS cycles.
  - clr_busy = (state==CLEAR).
  - clr_start while in CLEAR is ignored; the sweep does not restart.
  - While in CLEAR, wr_en_a, wr_en_b and busy_set are ignored, and bypass forwarding is disabled.
  - While in CLEAR, reads return the array contents, so entries not yet swept keep their old values.
  - rst_n low mid-sweep: immediate full reset and return to IDLE.
- Wrap-around: cnt wraps to 0 on the final increment; no out-of-range addresses exist.

Test Plan:
- Reset then read all 16 addresses on both ports → every read 0; busy_1=busy_2=0; clr_busy=0.
- Write A reg3=0x0ABCDE and read reg3 in the same cycle, BYPASS=1 → rd_data_1=0x0ABCDE combinationally. BYPASS=0 → read returns 0 that cycle and 0x0ABCDE the next.
- Same cycle: A writes reg5=0x111111 and B writes reg5=0x222222 → reg5=0x222222. Then write A reg0=0xFFFFFF → rd_addr_1=0 reads 0.
- busy_set reg7 → busy_1=1 for rd_addr_1=7. B writes reg7=0x00BEEF → busy_1=0 and rd_data_1=0x00BEEF in that cycle (BYPASS=1). busy_set and B write to reg7 in the same cycle → busy stays 1.
- Fill regs 1..15 with nonzero values and pulse clr_start:
  - clr_busy is high for exactly 16 cycles.
  - An A write to reg2 issued mid-sweep is dropped.
  - After the sweep, all registers read 0 and all busy bits are 0.
- Assert rst_n low at cycle 6 of a sweep → clr_busy=0 immediately; all registers read 0; a new clr_start is accepted afterwards.
